// File: rtl/bcd_converter_module_if.sv
// Token FIFO bundle for the binary-to-BCD node.
// slave = converter side, master = FIFO/testbench side.
interface bcd_converter_module_if #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
);
  logic [IN_WIDTH-1:0] entry_1;
  logic                empty;
  logic                full;
  logic                rd;
  logic                wr;
  logic [4*DIGITS-1:0] output_1;
  logic                busy;

  modport slave (
    input  entry_1,
    input  empty,
    input  full,
    output rd,
    output wr,
    output output_1,
    output busy
  );

  modport master (
    output entry_1,
    output empty,
    output full,
    input  rd,
    input  wr,
    input  output_1,
    input  busy
  );
endinterface

// File: rtl/bcd_converter_module.sv
// KPN node: pops a binary word, converts to packed BCD by
// sequential double-dabble (one bit per clock), pushes result.
module bcd_converter_module #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
) (
  input logic                    clk,
  input logic                    reset_n,
  bcd_converter_module_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_bin;
  logic [BW-1:0]       r_bcd;
  logic [BW-1:0]       r_out;
  logic [CW-1:0]       r_cnt;

  logic [BW-1:0]       w_adj;
  logic [BW-1:0]       w_bcd_nxt;
  logic                w_last;
  logic                w_rd;
  logic                w_wr;

  function automatic logic [BW-1:0] f_add3(
    input logic [BW-1:0] v
  );
    logic [BW-1:0] o;
    o = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5)
        o[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return o;
  endfunction

  assign w_adj     = f_add3(r_bcd);
  assign w_bcd_nxt = {w_adj[BW-2:0], r_bin[IN_WIDTH-1]};
  assign w_last    = (r_cnt == CW'(IN_WIDTH - 1));

  assign w_rd = reset_n & (r_state == S_IDLE) & ~bus.empty;
  assign w_wr = reset_n & (r_state == S_DONE) & ~bus.full;

  assign bus.rd       = w_rd;
  assign bus.wr       = w_wr;
  assign bus.output_1 = r_out;
  assign bus.busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rd) begin
            r_bin   <= bus.entry_1;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          // Rotate rather than shift: the dropped top-digit MSB
          // lands in the spent binary LSB, which is never read.
          r_bcd <= w_bcd_nxt;
          r_bin <= {r_bin[IN_WIDTH-2:0], w_adj[BW-1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_out   <= w_bcd_nxt;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (w_wr)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_module.sv
// Bench for bcd_converter_module: FIFO models on both sides,
// vector table plus scoreboard of expected BCD words.
module tb_bcd_converter_module;

  typedef struct {
    logic [31:0] din;
    logic [39:0] exp;
  } vec_t;

  logic clk;
  logic reset_n;

  bcd_converter_module_if #(.IN_WIDTH(32), .DIGITS(10)) bus();

  bcd_converter_module #(.IN_WIDTH(32), .DIGITS(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_rd  = 0;
  int exp_lat = 33;
  logic took = 1'b0;

  vec_t        in_q[$];
  logic [39:0] exp_q[$];
  int          rd_times[$];
  int          wr_times[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] model(logic [31:0] v);
    logic [39:0] r;
    longint unsigned t;
    r = '0;
    t = v;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Input FIFO model: show-ahead head, popped after a rd edge.
  always @(posedge clk) begin
    #1;
    if (took && in_q.size() > 0) void'(in_q.pop_front());
    took = 1'b0;
    bus.empty = (in_q.size() == 0);
    bus.entry_1 = (in_q.size() > 0) ? in_q[0].din : 32'd0;
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.rd && bus.wr) chk("rd_wr_overlap", 1, 0);
    if (bus.rd) begin
      took = 1'b1;
      t_rd = cyc;
      rd_times.push_back(cyc);
      if (in_q.size() > 0) exp_q.push_back(in_q[0].exp);
    end
    if (bus.wr) begin
      wr_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        chk("output_1", bus.output_1, exp_q.pop_front());
        chk("latency", cyc - t_rd, exp_lat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic enq(logic [31:0] d, logic [39:0] e);
    vec_t v;
    v.din = d;
    v.exp = e;
    in_q.push_back(v);
  endtask

  task automatic wait_rd(output int n);
    int i;
    n = -1;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rd) begin
        n = cyc;
        break;
      end
    end
    if (n < 0) chk("wait_rd_timeout", 1, 0);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_q.size() == 0 && exp_q.size() == 0 && !bus.busy)
        break;
    end
    if (i == 500) chk("drain_timeout", 1, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int errs;
    int nwr;
    logic [39:0] held;

    vecs[0] = '{32'd9,          40'h00_0000_0009};
    vecs[1] = '{32'd12345,      40'h00_0001_2345};
    vecs[2] = '{32'hFFFF_FFFF,  40'h42_9496_7295};
    vecs[3] = '{32'd0,          40'h00_0000_0000};
    vecs[4] = '{32'd100,        40'h00_0000_0100};
    vecs[5] = '{32'd99999999,   40'h00_9999_9999};
    vecs[6] = '{32'd1000000000, 40'h10_0000_0000};
    vecs[7] = '{32'd4000000000, 40'h40_0000_0000};

    reset_n     = 1'b0;
    bus.empty   = 1'b1;
    bus.full    = 1'b0;
    bus.entry_1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd", bus.rd, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out", bus.output_1, 0);
    step();
    reset_n = 1'b1;

    // Empty input for 100 cycles: nothing moves.
    errs = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.rd || bus.wr || bus.output_1 != 0) errs++;
    end
    chk("idle_quiet", errs, 0);

    foreach (vecs[i]) begin
      step();
      enq(vecs[i].din, vecs[i].exp);
      drain();
    end

    repeat (4) begin
      logic [31:0] r;
      r = $urandom;
      step();
      enq(r, model(r));
      drain();
    end

    // Busy window N+1..N+33.
    step();
    enq(32'd12345, 40'h00_0001_2345);
    wait_rd(n);
    @(negedge clk);
    chk("busy_n1", bus.busy, 1);
    repeat (32) @(negedge clk);
    chk("busy_n33", bus.busy, 1);
    chk("wr_n33", bus.wr, 1);
    @(negedge clk);
    chk("busy_n34", bus.busy, 0);
    drain();

    // Output FIFO full for 5 cycles of DONE.
    step();
    bus.full = 1'b1;
    exp_lat = 38;
    enq(32'd555, 40'h00_0000_0555);
    wait_rd(n);
    repeat (33) @(negedge clk);
    chk("full_wr", bus.wr, 0);
    chk("full_out", bus.output_1, 40'h555);
    chk("full_busy", bus.busy, 1);
    held = bus.output_1;
    errs = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wr || bus.output_1 != held) errs++;
    end
    chk("full_hold", errs, 0);
    nwr = wr_times.size();
    step();
    bus.full = 1'b0;
    drain();
    chk("full_release_wr", wr_times.size() - nwr, 1);
    exp_lat = 33;

    // Back-to-back tokens.
    step();
    rd_times.delete();
    wr_times.delete();
    enq(32'd12345, 40'h00_0001_2345);
    enq(32'd100,   40'h00_0000_0100);
    drain();
    chk("b2b_wr_count", wr_times.size(), 2);
    if (wr_times.size() == 2 && rd_times.size() == 2) begin
      chk("b2b_wr_gap", wr_times[1] - wr_times[0], 34);
      chk("b2b_rd_after_wr", rd_times[1] - wr_times[0], 1);
    end

    // Reset mid-conversion aborts the token.
    step();
    enq(32'hABCDEF, model(32'hABCDEF));
    wait_rd(n);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    nwr = wr_times.size();
    repeat (3) @(negedge clk);
    chk("abort_out", bus.output_1, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd", bus.rd, 0);
    step();
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_wr", wr_times.size() - nwr, 0);
    step();
    enq(32'd7, 40'h00_0000_0007);
    drain();
    chk("after_abort_wr", wr_times.size() - nwr, 1);
    chk("after_abort_out", bus.output_1, 40'h7);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
